mac_vector_unit: RTL

MAC_VECTOR_UNIT -- requirements
Module: mac_vector_unit

---
 rtl/mac_vector_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mac_vector_unit.sv
// rtl/mac_vector_unit.sv - pipelined multi-lane signed dot-product MAC with result handshake
// Optional clamping of the result to OUT_WIDTH: define MAC_VECTOR_SATURATE_EN.
module mac_vector_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic [LEN_WIDTH-1:0]          len,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   a_vec,
    input  logic [LANES*DATA_WIDTH-1:0]   b_vec,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_WIDTH-1:0]   out_data,
    output logic                          sat,
    output logic                          busy
);

    localparam int PW = 2*DATA_WIDTH + $clog2(LANES);
    localparam logic [1:0] DRAIN_LAST = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

    state_t                        state_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;
    logic signed [PW-1:0]          prod_q;
    logic                          prod_vld_q;
    logic [LEN_WIDTH-1:0]          cnt_q;
    logic [LEN_WIDTH-1:0]          len_q;
    logic [1:0]                    dcnt_q;
    logic                          in_ready_q;
    logic                          out_valid_q;
    logic signed [OUT_WIDTH-1:0]   out_data_q;
    logic                          sat_q;
    logic                          busy_q;

    logic signed [PW-1:0]          prod_sum_d;
    logic signed [DATA_WIDTH-1:0]  a_lane;
    logic signed [DATA_WIDTH-1:0]  b_lane;
    logic signed [2*DATA_WIDTH-1:0] lane_prod;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic signed [OUT_WIDTH-1:0]   res_d;
    logic                          sat_d;
    logic [LEN_WIDTH-1:0]          len_eff;
    logic [LEN_WIDTH-1:0]          cnt_inc;
    logic                          accept;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sat       = sat_q;
    assign busy      = busy_q;

    assign accept  = in_valid && in_ready_q;
    assign len_eff = (len == '0) ? LEN_WIDTH'(1) : len;
    assign cnt_inc = cnt_q + LEN_WIDTH'(1);
    assign shifted = acc_q >>> OUT_SHIFT;

    always_comb begin
        prod_sum_d = '0;
        a_lane     = '0;
        b_lane     = '0;
        lane_prod  = '0;
        for (int i = 0; i < LANES; i++) begin
            a_lane     = a_vec[i*DATA_WIDTH +: DATA_WIDTH];
            b_lane     = b_vec[i*DATA_WIDTH +: DATA_WIDTH];
            lane_prod  = a_lane * b_lane;
            prod_sum_d = prod_sum_d + PW'(lane_prod);
        end
    end

`ifdef MAC_VECTOR_SATURATE_EN
    logic [ACC_WIDTH-OUT_WIDTH:0] top_bits;
    assign top_bits = shifted[ACC_WIDTH-1:OUT_WIDTH-1];

    // The value fits when every bit above the result sign bit matches it.
    always_comb begin
        res_d = shifted[OUT_WIDTH-1:0];
        sat_d = 1'b0;
        if (!((&top_bits) || !(|top_bits))) begin
            sat_d = 1'b1;
            res_d = top_bits[ACC_WIDTH-OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                  : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end
`else
    assign res_d = shifted[OUT_WIDTH-1:0];
    assign sat_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            cnt_q       <= '0;
            len_q       <= '0;
            dcnt_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else if (clear) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            cnt_q       <= '0;
            len_q       <= '0;
            dcnt_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            prod_vld_q <= accept;
            if (accept)
                prod_q <= prod_sum_d;
            if (prod_vld_q)
                acc_q <= acc_q + ACC_WIDTH'(prod_q);

            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        len_q  <= len_eff;
                        cnt_q  <= LEN_WIDTH'(1);
                        acc_q  <= '0;
                        busy_q <= 1'b1;
                        dcnt_q <= '0;
                        if (len_eff == LEN_WIDTH'(1)) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == len_q) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                            dcnt_q     <= '0;
                        end
                    end
                end
                // Hold until the last product has passed both pipeline stages.
                DRAIN: begin
                    if (dcnt_q == DRAIN_LAST) begin
                        out_data_q  <= res_d;
                        sat_q       <= sat_d;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        dcnt_q <= dcnt_q + 2'd1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
